cnt_pipe_adder: RTL

Parametrised, pipelined successor to the team's combinational ripple-carry adder. It splits an N-bit add/subtract into SEG-bit carry-chain segments, with one register stage per segment. It accepts one operation per cycle under a valid/ready handshake with full backpressure. It is intended for wide datapaths where a single N-bit ripple chain misses timing.

---
 rtl/cnt_pkg.sv | 34 +++
 rtl/cnt_pipe_seg.sv | 44 ++++
 rtl/cnt_pipe_adder.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/cnt_pkg.sv
// ---------------------------------------------------------------------------
// cnt_pkg
// Shared definitions for the pipelined segmented adder:
//   num_stages()  - number of carry-chain segments (one register stage each)
//   CSEL_*        - encoding of the stage-0 carry select (driven by 'sub')
//   F_* / CTRL_W  - bit layout of the per-stage control word
//   full_add()    - the one-bit full-adder cell the segments are built from
// ---------------------------------------------------------------------------
package cnt_pkg;

   // Number of SEG-bit segments an N-bit operand splits into.
   function automatic int num_stages(input int n, input int seg);
      return n / seg;
   endfunction

   // Stage-0 carry select: external cin for add, forced 1 for subtract.
   localparam logic CSEL_EXT = 1'b0;
   localparam logic CSEL_SUB = 1'b1;

   // Control word held in every stage register next to the data fields.
   // CTOP is the carry into the most recent segment's top bit; once the
   // last segment has been added it is the carry into bit N-1.
   localparam int F_VALID = 0;
   localparam int F_CARRY = 1;
   localparam int F_CTOP  = 2;
   localparam int F_SUB   = 3;
   localparam int CTRL_W  = 4;

   // One-bit full adder, returned as {carry_out, sum}.
   function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
      return {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
   endfunction

endpackage

// File: rtl/cnt_pipe_seg.sv
// ---------------------------------------------------------------------------
// cnt_pipe_seg
// Purely combinational SEG-bit ripple-carry segment.
// Ports:
//   a, b   [SEG-1:0] in  : operand slices (b already inverted for subtract)
//   ci               in  : carry into bit 0 of the segment
//   sum    [SEG-1:0] out : segment sum
//   co               out : carry out of the segment's top bit
//   c_top            out : carry into the segment's top bit (for overflow)
// ---------------------------------------------------------------------------
module cnt_pipe_seg
   import cnt_pkg::*;
#(
   parameter int SEG = 4
) (
   input  logic [SEG-1:0] a,
   input  logic [SEG-1:0] b,
   input  logic           ci,
   output logic [SEG-1:0] sum,
   output logic           co,
   output logic           c_top
);

   // Ripple the carry through SEG full-adder cells, remembering the carry
   // that enters the top bit so overflow can be formed later.
   always_comb begin
      logic       carry;
      logic [1:0] fa;
      carry = ci;
      fa    = '0;
      sum   = '0;
      c_top = ci;
      for (int i = 0; i < SEG; i++) begin
         if (i == SEG - 1) begin
            c_top = carry;
         end
         fa     = full_add(a[i], b[i], carry);
         sum[i] = fa[0];
         carry  = fa[1];
      end
      co = carry;
   end

endmodule

// File: rtl/cnt_pipe_adder.sv
// ---------------------------------------------------------------------------
// cnt_pipe_adder
// Pipelined N-bit add/subtract, one SEG-bit carry segment per register stage,
// one operation per cycle under valid/ready with full backpressure.
// Ports:
//   clk, rst_n        : rising-edge clock, synchronous active-low reset
//   in_valid/in_ready : input handshake (in_ready never depends on in_valid)
//   a, b [N-1:0]      : operands
//   cin               : carry in (ignored when sub=1)
//   sub               : 0 -> a+b+cin, 1 -> a-b
//   out_valid/out_ready : output handshake
//   s [N-1:0]         : sum/difference modulo 2^N
//   cout              : carry out of bit N-1 (1 = no borrow when subtracting)
//   ovf               : two's-complement overflow
// ---------------------------------------------------------------------------
module cnt_pipe_adder
   import cnt_pkg::*;
#(
   parameter int N   = 8,
   parameter int SEG = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   input  logic         sub,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] s,
   output logic         cout,
   output logic         ovf
);

   localparam int STAGES = num_stages(N, SEG);

   if ((N % SEG) != 0 || N < SEG) begin : g_bad_params
      $error("cnt_pipe_adder: N must be a non-zero multiple of SEG");
   end

   logic [STAGES-1:0] vld;
   logic [STAGES-1:0] adv;

   // A stage may load when it is empty or when everything between it and
   // the output can move. Walking down from the output keeps in_ready free
   // of any path from in_valid, and lets an empty stage absorb a bubble
   // even while the output is stalled.
   always_comb begin
      logic run;
      run = out_ready | ~vld[STAGES-1];
      adv = '0;
      for (int k = STAGES - 1; k >= 0; k--) begin
         run    = run | ~vld[k];
         adv[k] = run;
      end
   end

   assign in_ready = adv[0];

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [N-1:0]      in_res;
      logic [N-1:0]      in_a;
      logic [N-1:0]      in_b;
      logic              in_c;
      logic              in_v;
      logic              in_sub;
      logic [SEG-1:0]    seg_sum;
      logic              seg_co;
      logic              seg_ctop;
      logic [N-1:0]      res_next;
      logic [CTRL_W-1:0] ctrl_next;
      logic [N-1:0]      res_q;
      logic [CTRL_W-1:0] ctrl_q;

      if (k == 0) begin : g_first
         assign in_res = '0;
         assign in_a   = a;
         assign in_b   = sub ? ~b : b;
         assign in_c   = (sub == CSEL_SUB) ? 1'b1 : cin;
         assign in_v   = in_valid;
         assign in_sub = sub;
      end else begin : g_next
         assign in_res = g_stage[k-1].res_q;
         assign in_a   = g_stage[k-1].g_fwd.a_q;
         assign in_b   = g_stage[k-1].g_fwd.b_q;
         assign in_c   = g_stage[k-1].ctrl_q[F_CARRY];
         assign in_v   = g_stage[k-1].ctrl_q[F_VALID];
         assign in_sub = g_stage[k-1].ctrl_q[F_SUB];
      end

      cnt_pipe_seg #(.SEG(SEG)) u_seg (
         .a     (in_a[k*SEG +: SEG]),
         .b     (in_b[k*SEG +: SEG]),
         .ci    (in_c),
         .sum   (seg_sum),
         .co    (seg_co),
         .c_top (seg_ctop)
      );

      // Next contents of this stage: the low result bits computed so far
      // with this segment's sum spliced in, plus the updated control word.
      always_comb begin
         res_next                 = in_res;
         res_next[k*SEG +: SEG]   = seg_sum;
         ctrl_next                = '0;
         ctrl_next[F_VALID]       = 1'b1;
         ctrl_next[F_CARRY]       = seg_co;
         ctrl_next[F_CTOP]        = seg_ctop;
         ctrl_next[F_SUB]         = in_sub;
      end

      // Result and control register. When the stage moves but nothing valid
      // arrives, only the valid bit drops so the data lines stay quiet;
      // when it does not move everything is held.
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            res_q  <= '0;
            ctrl_q <= '0;
         end else if (adv[k]) begin
            if (in_v) begin
               res_q  <= res_next;
               ctrl_q <= ctrl_next;
            end else begin
               ctrl_q[F_VALID] <= 1'b0;
            end
         end
      end

      // Operand bits still to be consumed travel with the op; the last
      // stage has none left, so it carries no operand registers.
      if (k < STAGES - 1) begin : g_fwd
         logic [N-1:0] a_q;
         logic [N-1:0] b_q;

         // Forward the (already inverted for subtract) operands alongside
         // the partial result, under the same load/hold rule.
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               a_q <= '0;
               b_q <= '0;
            end else if (adv[k] && in_v) begin
               a_q <= in_a;
               b_q <= in_b;
            end
         end
      end

      assign vld[k] = ctrl_q[F_VALID];
   end

   assign out_valid = vld[STAGES-1];
   assign s         = g_stage[STAGES-1].res_q;
   assign cout      = g_stage[STAGES-1].ctrl_q[F_CARRY];
   assign ovf       = g_stage[STAGES-1].ctrl_q[F_CTOP] ^ g_stage[STAGES-1].ctrl_q[F_CARRY];

endmodule
